// File: rtl/intf_cmd_router_pkg.sv
// Shared types and constants for the command router: FSM state encoding and
// the default read-data pattern returned on decode or timeout errors.
package intf_cmd_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESPOND,
    ST_RELEASE
  } state_t;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/intf_cmd.sv
// Upstream command interface: a level select with a single-cycle ack/rdata
// response driven by the slave side.
interface intf_cmd #(
  parameter int ADDR_BITS = 25,
  parameter int DATA_BITS = 32
);
  logic                 sel;
  logic                 rd_wr_n;
  logic [ADDR_BITS-1:0] byte_addr;
  logic [DATA_BITS-1:0] wdata;
  logic                 ack;
  logic [DATA_BITS-1:0] rdata;

  modport master (output sel, rd_wr_n, byte_addr, wdata, input  ack, rdata);
  modport slave  (input  sel, rd_wr_n, byte_addr, wdata, output ack, rdata);
endinterface

// File: rtl/cmd_timeout_ctr.sv
// Counts consecutive enabled cycles and flags expiry on the TIMEOUT_CYCLES-th
// one; a clear (or reset) restarts the count from zero.
module cmd_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != CNT_LAST)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_expire = i_enable && (r_count == CNT_LAST);

endmodule

// File: rtl/intf_cmd_router.sv
// Routes one upstream command at a time to a one-hot selected target, waits
// for that target's ack (or a timeout) and returns a single-cycle response.
module intf_cmd_router
  import intf_cmd_router_pkg::*;
#(
  parameter int NUM_BOARD_CMD_INTFS = 4,
  parameter int NUM_TARGETS         = 8,
  parameter int HOST_ADDRESS_BITS   = 25,
  parameter int TARGET_ADDRESS_BITS = 16,
  parameter int HOST_DATA_BITS      = 32,
  parameter int TIMEOUT_CYCLES      = 255,
  parameter logic [HOST_DATA_BITS-1:0] ERR_RDATA = HOST_DATA_BITS'(ERR_RDATA_DEFAULT)
) (
  input  logic                                  i_sys_clk,
  input  logic                                  i_sys_rst,
  intf_cmd.slave                                i_cmd_master,
  output logic [NUM_TARGETS-1:0]                o_tgt_sel,
  output logic                                  o_tgt_rd_wr_n,
  output logic [TARGET_ADDRESS_BITS-1:0]        o_tgt_byte_addr,
  output logic [HOST_DATA_BITS-1:0]             o_tgt_wdata,
  input  logic [NUM_TARGETS-1:0]                i_tgt_ack,
  input  logic [NUM_TARGETS*HOST_DATA_BITS-1:0] i_tgt_rdata,
  output logic                                  o_err,
  output logic [15:0]                           o_err_count
);
  localparam int BOARD_BITS = $clog2(NUM_BOARD_CMD_INTFS);
  localparam int IDX_BITS   = $clog2(NUM_TARGETS);
  localparam int SEL_HI     = HOST_ADDRESS_BITS - BOARD_BITS - 1;
  localparam int SEL_LO     = SEL_HI - IDX_BITS + 1;

  state_t r_state, w_next_state;

  logic [IDX_BITS-1:0]            r_idx;
  logic                           r_rd_wr_n;
  logic [TARGET_ADDRESS_BITS-1:0] r_byte_addr;
  logic [HOST_DATA_BITS-1:0]      r_wdata;
  logic [HOST_DATA_BITS-1:0]      r_rdata;
  logic                           r_err;
  logic [15:0]                    r_err_count;

  logic [IDX_BITS-1:0] w_idx;
  logic                w_idx_valid;
  logic                w_sel_ack;
  logic                w_expire;
  logic                w_capture;
  logic                w_take_ack;
  logic                w_take_timeout;
  logic                w_unused_addr;

  // Upper board-select bits and the address bits between the index field and
  // the forwarded target address play no part in routing.
  assign w_unused_addr = ^i_cmd_master.byte_addr;

  assign w_idx       = i_cmd_master.byte_addr[SEL_HI:SEL_LO];
  assign w_idx_valid = {1'b0, w_idx} < (IDX_BITS + 1)'(NUM_TARGETS);
  assign w_sel_ack   = i_tgt_ack[r_idx];

  cmd_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (i_sys_clk),
    .i_rst    (i_sys_rst),
    .i_clear  (r_state != ST_ACCESS),
    .i_enable (r_state == ST_ACCESS),
    .o_expire (w_expire)
  );

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    w_next_state   = r_state;
    w_capture      = 1'b0;
    w_take_ack     = 1'b0;
    w_take_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_cmd_master.sel) begin
          w_capture    = 1'b1;
          w_next_state = w_idx_valid ? ST_ACCESS : ST_RESPOND;
        end
      end
      ST_ACCESS: begin
        // Ack takes priority over a timeout expiring in the same cycle.
        if (w_sel_ack) begin
          w_take_ack   = 1'b1;
          w_next_state = ST_RESPOND;
        end else if (w_expire) begin
          w_take_timeout = 1'b1;
          w_next_state   = ST_RESPOND;
        end
      end
      ST_RESPOND: w_next_state = ST_RELEASE;
      ST_RELEASE: begin
        if (!i_cmd_master.sel) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_idx       <= '0;
      r_rd_wr_n   <= 1'b0;
      r_byte_addr <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else if (w_capture) begin
      r_idx       <= w_idx;
      r_rd_wr_n   <= i_cmd_master.rd_wr_n;
      r_byte_addr <= i_cmd_master.byte_addr[TARGET_ADDRESS_BITS-1:0];
      r_wdata     <= i_cmd_master.wdata;
      r_err       <= !w_idx_valid;
      if (!w_idx_valid) begin
        r_rdata <= ERR_RDATA;
      end
    end else if (w_take_ack) begin
      r_rdata <= i_tgt_rdata[int'(r_idx)*HOST_DATA_BITS +: HOST_DATA_BITS];
      r_err   <= 1'b0;
    end else if (w_take_timeout) begin
      r_rdata <= ERR_RDATA;
      r_err   <= 1'b1;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_err_count <= '0;
    end else if (o_err && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign o_tgt_sel       = (r_state == ST_ACCESS) ? (NUM_TARGETS'(1) << r_idx) : '0;
  assign o_tgt_rd_wr_n   = r_rd_wr_n;
  assign o_tgt_byte_addr = r_byte_addr;
  assign o_tgt_wdata     = r_wdata;
  assign o_err           = (r_state == ST_RESPOND) && r_err;
  assign o_err_count     = r_err_count;

  assign i_cmd_master.ack   = (r_state == ST_RESPOND);
  assign i_cmd_master.rdata = r_rdata;

endmodule

// File: tb/tb_intf_cmd_router.sv
// Directed bench for intf_cmd_router with 6 targets and a 4-cycle timeout:
// table-driven transactions plus hand-written reset sequences.
module tb_intf_cmd_router;

  localparam int NT = 6;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [NT-1:0]   o_tgt_sel;
  logic            o_tgt_rd_wr_n;
  logic [15:0]     o_tgt_byte_addr;
  logic [DW-1:0]   o_tgt_wdata;
  logic [NT-1:0]   i_tgt_ack;
  logic [NT*DW-1:0] i_tgt_rdata;
  logic            o_err;
  logic [15:0]     o_err_count;

  int errors = 0;
  int checks = 0;

  intf_cmd #(.ADDR_BITS(25), .DATA_BITS(DW)) cmd_if ();

  intf_cmd_router #(
    .NUM_BOARD_CMD_INTFS (4),
    .NUM_TARGETS         (NT),
    .HOST_ADDRESS_BITS   (25),
    .TARGET_ADDRESS_BITS (16),
    .HOST_DATA_BITS      (DW),
    .TIMEOUT_CYCLES      (4),
    .ERR_RDATA           (32'hDEAD_BEEF)
  ) dut (
    .i_sys_clk       (clk),
    .i_sys_rst       (rst),
    .i_cmd_master    (cmd_if),
    .o_tgt_sel       (o_tgt_sel),
    .o_tgt_rd_wr_n   (o_tgt_rd_wr_n),
    .o_tgt_byte_addr (o_tgt_byte_addr),
    .o_tgt_wdata     (o_tgt_wdata),
    .i_tgt_ack       (i_tgt_ack),
    .i_tgt_rdata     (i_tgt_rdata),
    .o_err           (o_err),
    .o_err_count     (o_err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] addr;
    logic        rd_wr_n;
    logic [31:0] wdata;
    int          ack_at;      // ACCESS cycle (1-based) carrying the ack, 0 = never
    logic [5:0]  spur;        // acks from other targets driven every ACCESS cycle
    bit          drop_early;  // upstream sel falls during ACCESS
    logic [5:0]  exp_sel;
    int          exp_cycles;
    logic [31:0] exp_rdata;
    int          exp_err;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int sel_cycles = 0;
    int acks = 0;
    int errs = 0;
    int retrig = 0;
    int post = 0;
    int stable_bad = 0;
    logic [31:0] got_rdata = '0;
    bit done = 0;
    cmd_if.sel       = 1'b1;
    cmd_if.byte_addr = v.addr;
    cmd_if.rd_wr_n   = v.rd_wr_n;
    cmd_if.wdata     = v.wdata;
    for (int c = 0; c < 40 && !done; c++) begin
      step();
      if (acks == 0) begin
        if (o_tgt_sel != '0) begin
          sel_cycles++;
          if (sel_cycles == 1) begin
            check($sformatf("v%0d tgt_sel", n), 64'(o_tgt_sel), 64'(v.exp_sel));
            check($sformatf("v%0d tgt_addr", n), 64'(o_tgt_byte_addr), 64'(v.addr[15:0]));
            check($sformatf("v%0d tgt_wdata", n), 64'(o_tgt_wdata), 64'(v.wdata));
            check($sformatf("v%0d tgt_rd_wr_n", n), 64'(o_tgt_rd_wr_n), 64'(v.rd_wr_n));
            if (v.drop_early) cmd_if.sel = 1'b0;
          end else if (o_tgt_byte_addr !== v.addr[15:0] || o_tgt_wdata !== v.wdata ||
                       o_tgt_rd_wr_n !== v.rd_wr_n) begin
            stable_bad++;
          end
          i_tgt_ack = (sel_cycles == v.ack_at) ? (v.exp_sel | v.spur) : v.spur;
        end else begin
          i_tgt_ack = '0;
        end
      end else begin
        i_tgt_ack = '0;
        if (o_tgt_sel != '0) retrig++;
        post++;
        if (post == 3) cmd_if.sel = 1'b0;
        if (post == 5) done = 1;
      end
      if (cmd_if.ack) begin
        acks++;
        got_rdata = cmd_if.rdata;
      end
      if (o_err) errs++;
    end
    check($sformatf("v%0d completed in budget", n), 64'(done), 64'd1);
    check($sformatf("v%0d sel cycles", n), 64'(sel_cycles), 64'(v.exp_cycles));
    check($sformatf("v%0d upstream acks", n), 64'(acks), 64'd1);
    check($sformatf("v%0d rdata", n), 64'(got_rdata), 64'(v.exp_rdata));
    check($sformatf("v%0d err pulses", n), 64'(errs), 64'(v.exp_err));
    check($sformatf("v%0d retrigger", n), 64'(retrig), 64'd0);
    check($sformatf("v%0d stable tgt outputs", n), 64'(stable_bad), 64'd0);
    check($sformatf("v%0d err_count", n), 64'(o_err_count), 64'(v.exp_cnt));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " tgt_sel"}, 64'(o_tgt_sel), 64'd0);
    check({tag, " ack"}, 64'(cmd_if.ack), 64'd0);
    check({tag, " rdata"}, 64'(cmd_if.rdata), 64'd0);
    check({tag, " err"}, 64'(o_err), 64'd0);
    check({tag, " err_count"}, 64'(o_err_count), 64'd0);
    check({tag, " tgt_addr"}, 64'(o_tgt_byte_addr), 64'd0);
    check({tag, " tgt_wdata"}, 64'(o_tgt_wdata), 64'd0);
    check({tag, " tgt_rd_wr_n"}, 64'(o_tgt_rd_wr_n), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int quiet_ack;
    int quiet_sel;

    //          addr           rw    wdata          ack spur       drop exp_sel     cyc rdata          err cnt
    vecs[0] = '{25'h0B0_1234, 1'b0, 32'h1234_5678, 3, 6'b000000, 0, 6'b001000, 3, 32'hCAFE_0003, 0, 16'd0};
    vecs[1] = '{25'h0D0_5678, 1'b1, 32'h0000_0000, 2, 6'b000100, 0, 6'b100000, 2, 32'hCAFE_0005, 0, 16'd0};
    vecs[2] = '{25'h020_0010, 1'b1, 32'h0000_0000, 0, 6'b000000, 0, 6'b000100, 4, 32'hDEAD_BEEF, 1, 16'd1};
    vecs[3] = '{25'h1F0_FFFF, 1'b1, 32'h0000_0000, 0, 6'b000000, 0, 6'b000000, 0, 32'hDEAD_BEEF, 1, 16'd2};
    vecs[4] = '{25'h011_0ABC, 1'b0, 32'hA5A5_0001, 3, 6'b000000, 1, 6'b000010, 3, 32'hCAFE_0001, 0, 16'd2};
    vecs[5] = '{25'h000_0002, 1'b1, 32'h0000_0000, 1, 6'b000000, 0, 6'b000001, 1, 32'hCAFE_0000, 0, 16'd2};
    vecs[6] = '{25'h060_0000, 1'b0, 32'h5555_AAAA, 0, 6'b000000, 0, 6'b000000, 0, 32'hDEAD_BEEF, 1, 16'd3};
    vecs[7] = '{25'h040_0100, 1'b1, 32'h0000_0000, 4, 6'b000000, 0, 6'b010000, 4, 32'hCAFE_0004, 0, 16'd3};

    for (int k = 0; k < NT; k++) i_tgt_rdata[k*DW +: DW] = 32'hCAFE_0000 + 32'(k);
    i_tgt_ack        = '0;
    cmd_if.sel       = 1'b0;
    cmd_if.rd_wr_n   = 1'b0;
    cmd_if.byte_addr = '0;
    cmd_if.wdata     = '0;
    rst              = 1'b1;
    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      run_vec(i, vecs[i]);
      repeat (2) step();
    end

    // Reset in the middle of an ACCESS: everything clears, no ack follows.
    cmd_if.sel       = 1'b1;
    cmd_if.byte_addr = 25'h040_4242;
    cmd_if.rd_wr_n   = 1'b0;
    cmd_if.wdata     = 32'hAAAA_5555;
    step();
    check("midrst access sel", 64'(o_tgt_sel), 64'h10);
    check("midrst access wdata", 64'(o_tgt_wdata), 64'hAAAA_5555);
    step();
    rst        = 1'b1;
    cmd_if.sel = 1'b0;
    step();
    check_all_zero("midrst");
    rst       = 1'b0;
    quiet_ack = 0;
    quiet_sel = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (cmd_if.ack) quiet_ack++;
      if (o_tgt_sel != '0) quiet_sel++;
    end
    check("midrst no late ack", 64'(quiet_ack), 64'd0);
    check("midrst no late sel", 64'(quiet_sel), 64'd0);

    // A fresh transaction after the reset, with sel held through RELEASE.
    run_vec(8, '{25'h0B0_00F0, 1'b0, 32'h0BAD_F00D, 2, 6'b000000, 0, 6'b001000, 2,
                 32'hCAFE_0003, 0, 16'd0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/intf_cmd_router.md
INTF_CMD_ROUTER -- requirements
Module: intf_cmd_router

Interface
REQ-001 SHALL have parameter NUM_BOARD_CMD_INTFS, default 4, meaning the number of upstream fmc_bridge command interfaces (sets upper address bits skipped).
REQ-002 SHALL have parameter NUM_TARGETS, default 8, range 2..64, meaning the number of downstream targets (need not be a power of 2).
REQ-003 SHALL have parameter HOST_ADDRESS_BITS, default 25, meaning the upstream byte_addr width.
REQ-004 SHALL have parameter TARGET_ADDRESS_BITS, default 16, meaning the byte_addr width forwarded to targets.
REQ-005 SHALL have parameter HOST_DATA_BITS, default 32, meaning the wdata/rdata width.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 255, range 1..65535, meaning the number of ACCESS cycles without ack before abort.
REQ-007 SHALL have parameter ERR_RDATA, default 32'hDEAD_BEEF, meaning rdata returned on decode or timeout error.
REQ-008 SHALL have port i_sys_clk, input, 1 bit: the single clock; all logic rises on it.
REQ-009 SHALL have port i_sys_rst, input, 1 bit: reset, synchronous and active-high.
REQ-010 SHALL have port i_cmd_master, intf_cmd.slave: upstream command (sel, rd_wr_n, byte_addr, wdata in; ack, rdata out).
REQ-011 SHALL have port o_tgt_sel, output, NUM_TARGETS bits: one-hot target select.
REQ-012 SHALL have port o_tgt_rd_wr_n, output, 1 bit: registered rd_wr_n shared by all targets.
REQ-013 SHALL have port o_tgt_byte_addr, output, TARGET_ADDRESS_BITS bits: registered byte_addr[TARGET_ADDRESS_BITS-1:0].
REQ-014 SHALL have port o_tgt_wdata, output, HOST_DATA_BITS bits: registered wdata.
REQ-015 SHALL have port i_tgt_ack, input, NUM_TARGETS bits: per-target ack.
REQ-016 SHALL have port i_tgt_rdata, input, NUM_TARGETS*HOST_DATA_BITS bits: per-target rdata, target k at bits [k*HOST_DATA_BITS +: HOST_DATA_BITS].
REQ-017 SHALL have port o_err, output, 1 bit: one-cycle pulse on decode error or timeout.
REQ-018 SHALL have port o_err_count, output, 16 bits: saturating count of errors.

Function
REQ-019 SHALL decode target index idx = byte_addr[SEL_HI:SEL_LO], SEL_HI = HOST_ADDRESS_BITS-clog2(NUM_BOARD_CMD_INTFS)-1, SEL_LO = SEL_HI-clog2(NUM_TARGETS)+1.
REQ-020 SHALL implement FSM IDLE, ACCESS, RESPOND, RELEASE.
REQ-021 IDLE: sel=1 -> capture idx, rd_wr_n, byte_addr, wdata; go ACCESS if idx<NUM_TARGETS, else RESPOND with error.
REQ-022 ACCESS: o_tgt_sel[idx]=1, all other bits 0; first asserted the cycle after sel is sampled (1-cycle latency).
REQ-023 ACCESS: i_tgt_ack[idx]=1 -> capture i_tgt_rdata slice idx, drop o_tgt_sel next cycle, go RESPOND; acks from other targets ignored.
REQ-024 ACCESS: TIMEOUT_CYCLES consecutive cycles without ack -> drop o_tgt_sel, load ERR_RDATA, go RESPOND with error; ack and timeout on the same cycle -> ack wins.
REQ-025 RESPOND: i_cmd_master.ack=1 for exactly one cycle with rdata valid (ERR_RDATA on error); o_err pulses in this same cycle on error; go RELEASE.
REQ-026 RELEASE: remain until i_cmd_master.sel=0, then IDLE; a sel held high never retriggers a second access.
REQ-027 Upstream sel dropping during ACCESS SHALL NOT abort; the transaction completes and RESPOND still acks.
REQ-028 o_err_count SHALL increment on each o_err pulse and saturate at 16'hFFFF.
REQ-029 o_tgt_rd_wr_n, o_tgt_byte_addr and o_tgt_wdata SHALL be stable while any o_tgt_sel bit is high.

Reset
REQ-030 When i_sys_rst=1, the next clock edge SHALL force FSM=IDLE, o_tgt_sel=0, i_cmd_master.ack=0, rdata=0, o_err=0, o_err_count=0, timeout counter=0, and all registered target outputs=0; this holds mid-transaction, with no ack issued for an aborted command.

Structure
REQ-031 Package intf_cmd_router_pkg SHALL hold the FSM state enum typedef and the ERR_RDATA default constant.
REQ-032 Sub-module cmd_timeout_ctr SHALL hold the clear/enable/expire counter, parameterised by TIMEOUT_CYCLES.

Verification
REQ-033 Write: byte_addr selects idx=3, wdata=32'h1234_5678; ack after 2 cycles -> o_tgt_sel=8'b0000_1000 one cycle after sel; o_tgt_wdata=32'h1234_5678; one upstream ack.
REQ-034 Read: idx=5 returns 32'hCAFE_0005 -> upstream rdata=32'hCAFE_0005 with ack; spurious i_tgt_ack[2] is ignored.
REQ-035 Timeout: TIMEOUT_CYCLES=4, no ack -> sel high exactly 4 cycles; ack with 32'hDEAD_BEEF; o_err pulse; o_err_count=1.
REQ-036 Decode error: NUM_TARGETS=6, idx=7 -> o_tgt_sel stays 0; ack with ERR_RDATA; o_err=1.
REQ-037 Reset mid-ACCESS, then sel held high through RELEASE -> all outputs 0 after reset edge; no duplicate access before sel falls.
